// File: rtl/espi_mux_sequencer_if.sv
// ---------------------------------------------------------------------------
// espi_mux_sequencer_if
// Groups the reset, tick, handshake and mux-select signals of the eSPI mux
// sequencer. Clock and reset stay plain ports on the module.
//
// Signals:
//   i1uSCE          one-clock pulse every 1 us
//   iRsmRst_N       PCH RSMRST#, synchronized, low = in reset
//   RST_SRST_BMC_N  BMC SRST#, synchronized, low = in reset
//   iReStrapReq     BMC re-strap request (four-phase level)
//   oEspiMuxPCHSel  PCH mux select, 0 = strap, 1 = eSPI function
//   oEspiMuxBMCSel  BMC mux select, 0 = strap, 1 = eSPI function
//   oEspiReady      both sides in function mode
//   oReStrapAck     re-strap acknowledge
//   oState          current state encoding, for debug
//
// Modports:
//   master  board / bench side: drives the inputs, observes the outputs
//   slave   sequencer side
// ---------------------------------------------------------------------------
interface espi_mux_sequencer_if;
    logic       i1uSCE;
    logic       iRsmRst_N;
    logic       RST_SRST_BMC_N;
    logic       iReStrapReq;
    logic       oEspiMuxPCHSel;
    logic       oEspiMuxBMCSel;
    logic       oEspiReady;
    logic       oReStrapAck;
    logic [2:0] oState;

    modport master (
        output i1uSCE, iRsmRst_N, RST_SRST_BMC_N, iReStrapReq,
        input  oEspiMuxPCHSel, oEspiMuxBMCSel, oEspiReady, oReStrapAck, oState
    );

    modport slave (
        input  i1uSCE, iRsmRst_N, RST_SRST_BMC_N, iReStrapReq,
        output oEspiMuxPCHSel, oEspiMuxBMCSel, oEspiReady, oReStrapAck, oState
    );
endinterface

// File: rtl/espi_mux_sequencer.sv
// ---------------------------------------------------------------------------
// espi_mux_sequencer
// Sequences the eSPI strap/function muxes for the PCH and BMC sides. Both
// muxes stay in strap position until PCH RSMRST# and BMC SRST# are both
// released, then the straps are held for STRAP_HOLD_US microsecond ticks,
// the BMC side is switched to function mode, and after GUARD_US ticks the
// PCH side follows. A BMC re-strap request drains in reverse order (PCH
// first) and completes a four-phase request/acknowledge handshake.
//
// Parameters:
//   STRAP_HOLD_US  ticks spent holding straps (1..255, 0 behaves as 1)
//   GUARD_US       ticks between BMC and PCH select edges (1..255, 0 as 1)
//
// Ports:
//   iClk    system clock
//   iRst_n  synchronous active-low reset
//   bus     espi_mux_sequencer_if.slave (tick, resets, handshake, selects)
// ---------------------------------------------------------------------------
module espi_mux_sequencer #(
    parameter int unsigned STRAP_HOLD_US = 2,
    parameter int unsigned GUARD_US      = 1
) (
    input  logic                  iClk,
    input  logic                  iRst_n,
    espi_mux_sequencer_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HOLD    = 3'd1,
        BMC_ON  = 3'd2,
        ACTIVE  = 3'd3,
        DRAIN   = 3'd4,
        RESTRAP = 3'd5
    } state_t;

    // Terminal count values; a zero parameter collapses to a one-tick phase.
    localparam logic [7:0] HOLD_LAST  = (STRAP_HOLD_US == 0) ? 8'd0 : 8'(STRAP_HOLD_US - 1);
    localparam logic [7:0] GUARD_LAST = (GUARD_US == 0)      ? 8'd0 : 8'(GUARD_US - 1);

    state_t     r_state;
    logic [7:0] r_count;
    logic       r_pchSel;
    logic       r_bmcSel;
    logic       r_ready;
    logic       r_ack;

    state_t     w_nextState;
    logic [7:0] w_nextCount;
    logic       w_resetsHigh;

    assign w_resetsHigh = bus.iRsmRst_N & bus.RST_SRST_BMC_N;

    // Next-state logic. A low reset input wins over everything else,
    // including a terminal tick arriving in the same cycle. The timed
    // phases count ticks upward and leave on the tick that hits the
    // terminal value; the counter restarts at zero on every state change.
    always_comb begin
        w_nextState = r_state;
        w_nextCount = r_count;
        if (!w_resetsHigh) begin
            w_nextState = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    w_nextState = HOLD;
                end
                HOLD: begin
                    if (bus.i1uSCE) begin
                        if (r_count == HOLD_LAST) w_nextState = BMC_ON;
                        else                      w_nextCount = r_count + 8'd1;
                    end
                end
                BMC_ON: begin
                    if (bus.i1uSCE) begin
                        if (r_count == GUARD_LAST) w_nextState = ACTIVE;
                        else                       w_nextCount = r_count + 8'd1;
                    end
                end
                ACTIVE: begin
                    if (bus.iReStrapReq) w_nextState = DRAIN;
                end
                DRAIN: begin
                    if (bus.i1uSCE) begin
                        if (r_count == GUARD_LAST) w_nextState = RESTRAP;
                        else                       w_nextCount = r_count + 8'd1;
                    end
                end
                RESTRAP: begin
                    if (!bus.iReStrapReq) w_nextState = HOLD;
                end
                default: begin
                    w_nextState = IDLE;
                end
            endcase
        end
        if (w_nextState != r_state) w_nextCount = 8'd0;
    end

    // State, counter and outputs. Outputs are decoded from the next state
    // so they move on the same edge as the debug state.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            r_state  <= IDLE;
            r_count  <= 8'd0;
            r_pchSel <= 1'b0;
            r_bmcSel <= 1'b0;
            r_ready  <= 1'b0;
            r_ack    <= 1'b0;
        end else begin
            r_state  <= w_nextState;
            r_count  <= w_nextCount;
            r_bmcSel <= (w_nextState == BMC_ON) || (w_nextState == ACTIVE) ||
                        (w_nextState == DRAIN);
            r_pchSel <= (w_nextState == ACTIVE);
            r_ready  <= (w_nextState == ACTIVE);
            r_ack    <= (w_nextState == RESTRAP);
        end
    end

    assign bus.oEspiMuxPCHSel = r_pchSel;
    assign bus.oEspiMuxBMCSel = r_bmcSel;
    assign bus.oEspiReady     = r_ready;
    assign bus.oReStrapAck    = r_ack;
    assign bus.oState         = r_state;

endmodule
